// File: rtl/mult_rr_scheduler_if.sv
// Requester and multiplier-side signals of the shared multiplier scheduler.
// slave = scheduler side, master = requesters plus the multiplier.
interface mult_rr_scheduler_if #(
   parameter int DW = 8,
   parameter int N  = 4
);
   logic [N-1:0]      req;
   logic [N*DW-1:0]   req_a;
   logic [N*DW-1:0]   req_b;
   logic [N-1:0]      grant;
   logic [N-1:0]      done;
   logic [N-1:0]      err;
   logic [2*DW-1:0]   result;
   logic              busy;
   logic              mult_start;
   logic [DW-1:0]     mult_a;
   logic [DW-1:0]     mult_b;
   logic              mult_ready;
   logic [2*DW-1:0]   mult_product;

   modport slave (
      input  req, req_a, req_b, mult_ready, mult_product,
      output grant, done, err, result, busy, mult_start, mult_a, mult_b
   );

   modport master (
      output req, req_a, req_b, mult_ready, mult_product,
      input  grant, done, err, result, busy, mult_start, mult_a, mult_b
   );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one multiplier among N requesters, with a watchdog.
//  state  | meaning
//  IDLE   | waiting for any req; picks first set bit at/after ptr
//  LAUNCH | operands registered, mult_start high for this one cycle
//  WAIT   | watchdog counting down; waiting for a rising edge of mult_ready
//  DONE   | done[owner] high, ptr moves past owner
module mult_rr_scheduler #(
   parameter int DW      = 8,
   parameter int N       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   mult_rr_scheduler_if.slave   bus
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     r_owner;
   logic [N-1:0]      r_grant;
   logic [N-1:0]      r_done;
   logic [N-1:0]      r_err;
   logic [2*DW-1:0]   r_result;
   logic [DW-1:0]     r_mult_a;
   logic [DW-1:0]     r_mult_b;
   logic              r_mult_start;
   logic              r_busy;
   logic              r_ready_q;
   logic [WW-1:0]     r_wdog;

   logic [N-1:0]      w_rot;
   logic [PW-1:0]     w_off;
   logic [PW:0]       w_sum;
   logic [PW-1:0]     w_pick;
   logic [N-1:0]      w_pick_oh;
   logic [DW-1:0]     w_pick_a;
   logic [DW-1:0]     w_pick_b;
   logic [PW-1:0]     w_next_ptr;
   logic              w_ready_rise;

   // Rotate requests so bit 0 is the ptr position; the lowest set bit wins.
   always_comb begin
      w_rot = N'({bus.req, bus.req} >> r_ptr);
      w_off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = PW'(k);
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= (PW+1)'(N)) w_pick = PW'(w_sum - (PW+1)'(N));
      else                     w_pick = PW'(w_sum);
      w_pick_a = '0;
      w_pick_b = '0;
      for (int k = 0; k < N; k++) begin
         if (w_pick == PW'(k)) begin
            w_pick_a = bus.req_a[k*DW +: DW];
            w_pick_b = bus.req_b[k*DW +: DW];
         end
      end
   end

   assign w_pick_oh    = N'(1) << w_pick;
   assign w_next_ptr   = (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;
   assign w_ready_rise = bus.mult_ready & ~r_ready_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_owner      <= '0;
         r_grant      <= '0;
         r_done       <= '0;
         r_err        <= '0;
         r_result     <= '0;
         r_mult_a     <= '0;
         r_mult_b     <= '0;
         r_mult_start <= 1'b0;
         r_busy       <= 1'b0;
         r_ready_q    <= 1'b0;
         r_wdog       <= '0;
      end else begin
         r_ready_q    <= bus.mult_ready;
         r_mult_start <= 1'b0;
         r_done       <= '0;
         r_err        <= '0;
         case (r_state)
            S_IDLE: begin
               if (|bus.req) begin
                  r_owner      <= w_pick;
                  r_grant      <= w_pick_oh;
                  r_mult_a     <= w_pick_a;
                  r_mult_b     <= w_pick_b;
                  r_mult_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_wdog  <= WW'(TIMEOUT - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A ready already high on entry has r_ready_q set, so only a fresh edge completes.
               if (w_ready_rise) begin
                  r_result <= bus.mult_product;
                  r_done   <= r_grant;
                  r_state  <= S_DONE;
               end else if (r_wdog == '0) begin
                  r_err   <= r_grant;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_next_ptr;
                  r_state <= S_IDLE;
               end else begin
                  r_wdog <= r_wdog - 1'b1;
               end
            end
            S_DONE: begin
               r_ptr   <= w_next_ptr;
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.grant      = r_grant;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.result     = r_result;
   assign bus.busy       = r_busy;
   assign bus.mult_start = r_mult_start;
   assign bus.mult_a     = r_mult_a;
   assign bus.mult_b     = r_mult_b;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: emulated multiplier plus a round-robin reference model.
module tb_mult_rr_scheduler;
   localparam int DW      = 8;
   localparam int N       = 4;
   localparam int TIMEOUT = 64;
   localparam int RW      = 2 * DW;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_err = 0;
   int   n_chk = 0;

   mult_rr_scheduler_if #(.DW(DW), .N(N)) bus ();

   mult_rr_scheduler #(.DW(DW), .N(N), .TIMEOUT(TIMEOUT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // multiplier emulation: 0 = normal, 1 = never ready, 2 = ready held high then re-pulsed
   int            model_mode = 0;
   int            model_lat  = 1;
   int            n_start    = 0;
   time           t_fall     = 0;
   int            m_cnt      = 0;
   bit            m_rise     = 1'b0;
   logic [DW-1:0] m_a, m_b;
   int            m_pa, m_pb;

   logic [DW-1:0] op_a [N];
   logic [DW-1:0] op_b [N];

   initial begin
      bus.mult_ready   = 1'b0;
      bus.mult_product = '0;
      bus.req          = '0;
      bus.req_a        = '0;
      bus.req_b        = '0;
      forever begin
         @(negedge clk);
         if (m_rise) begin
            bus.mult_ready = 1'b1;
            m_rise = 1'b0;
         end else if (bus.mult_start === 1'b1) begin
            n_start++;
            m_a   = bus.mult_a;
            m_b   = bus.mult_b;
            m_cnt = (model_mode == 1) ? 0 : model_lat;
            bus.mult_ready = (model_mode == 2);
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_pa = int'($signed(m_a));
               m_pb = int'($signed(m_b));
               bus.mult_product = RW'(m_pa * m_pb);
               if (model_mode == 2) begin
                  bus.mult_ready = 1'b0;
                  m_rise = 1'b1;
                  t_fall = $time;
               end else begin
                  bus.mult_ready = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   function automatic logic [RW-1:0] exp_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [RW-1:0] sa, sb;
      sa = {{DW{a[DW-1]}}, a};
      sb = {{DW{b[DW-1]}}, b};
      return sa * sb;
   endfunction

   task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      op_a[i] = a;
      op_b[i] = b;
      bus.req_a[i*DW +: DW] = a;
      bus.req_b[i*DW +: DW] = b;
   endtask

   task automatic wait_grant(output logic [N-1:0] g, output bit ok);
      ok = 1'b0;
      g  = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.grant !== '0) begin
            g  = bus.grant;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_end(output logic [N-1:0] d, output logic [N-1:0] e, output int cyc, output bit ok);
      ok  = 1'b0;
      d   = '0;
      e   = '0;
      cyc = 0;
      for (int i = 0; i < TIMEOUT + 50; i++) begin
         @(negedge clk);
         cyc++;
         if ((bus.done | bus.err) !== '0) begin
            d  = bus.done;
            e  = bus.err;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic do_reset();
      bus.req    = '0;
      model_mode = 0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (bus.grant !== '0)      begin n_err++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
      n_chk++; if (bus.done !== '0)       begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_chk++; if (bus.err !== '0)        begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err); end
      n_chk++; if (bus.result !== '0)     begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
      n_chk++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_chk++; if (bus.mult_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.mult_start); end
      n_chk++; if ({bus.mult_a, bus.mult_b} !== '0) begin n_err++; $display("FAIL reset_operands: got %h/%h want 0", bus.mult_a, bus.mult_b); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if ({bus.busy, bus.grant} !== '0) begin n_err++; $display("FAIL idle_after_reset: busy=%b grant=%b want 0", bus.busy, bus.grant); end
   endtask

   task automatic test_single();
      logic [N-1:0] g, d, e;
      int cyc, n0;
      bit ok;
      n0 = n_start;
      model_lat = 2;
      set_op(0, 8'd3, 8'd5);
      bus.req = 4'b0001;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", g); end
      n_chk++; if (bus.mult_start !== 1'b1 || bus.mult_a !== 8'd3 || bus.mult_b !== 8'd5) begin
         n_err++; $display("FAIL single_launch: start=%b a=%h b=%h want 1/03/05", bus.mult_start, bus.mult_a, bus.mult_b); end
      wait_end(d, e, cyc, ok);
      bus.req = '0;
      n_chk++; if (!ok || d !== 4'b0001 || e !== '0) begin n_err++; $display("FAIL single_done: done=%b err=%b want 0001/0000", d, e); end
      n_chk++; if (bus.result !== 16'd15) begin n_err++; $display("FAIL single_result: got %h want 000f", bus.result); end
      n_chk++; if (cyc != 3) begin n_err++; $display("FAIL single_latency: got %0d cycles want 3", cyc); end
      @(negedge clk);
      n_chk++; if (bus.done !== '0 || bus.grant !== '0) begin n_err++; $display("FAIL single_pulse: done=%b grant=%b want 0", bus.done, bus.grant); end
      repeat (4) @(negedge clk);
      n_chk++; if (n_start - n0 != 1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_starts: starts=%0d busy=%b want 1/0", n_start - n0, bus.busy); end
   endtask

   task automatic test_signed();
      logic [N-1:0] g, d, e;
      int cyc;
      bit ok;
      model_lat = 3;
      set_op(2, 8'hFC, 8'd7);
      bus.req = 4'b0100;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== 4'b0100) begin n_err++; $display("FAIL signed_grant: got %b want 0100", g); end
      wait_end(d, e, cyc, ok);
      bus.req = '0;
      n_chk++; if (!ok || d !== 4'b0100 || e !== '0) begin n_err++; $display("FAIL signed_done: done=%b err=%b want 0100/0000", d, e); end
      n_chk++; if (bus.result !== 16'hFFE4) begin n_err++; $display("FAIL signed_result: got %h want ffe4", bus.result); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [N-1:0] g, d, e, prev;
      int cyc, w, ptr;
      bit ok;
      do_reset();
      ptr  = 0;
      prev = '0;
      for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
      model_lat = 2;
      bus.req = '1;
      for (int j = 0; j <= N; j++) begin
         wait_grant(g, ok);
         w = rr_pick(ptr, '1);
         n_chk++; if (!ok || g !== onehot(w)) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", j, g, onehot(w)); end
         n_chk++; if (g === prev) begin n_err++; $display("FAIL rr_repeat[%0d]: granted %b twice in a row", j, g); end
         wait_end(d, e, cyc, ok);
         n_chk++; if (!ok || d !== onehot(w) || bus.result !== exp_prod(op_a[w], op_b[w])) begin
            n_err++; $display("FAIL rr_done[%0d]: done=%b result=%h want %b/%h", j, d, bus.result, onehot(w), exp_prod(op_a[w], op_b[w])); end
         prev = g;
         ptr  = (w + 1) % N;
         model_lat = $urandom_range(1, 5);
         if (j == N) bus.req = '0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      logic [N-1:0] g, d, e, req_v, nw;
      int cyc, w, ptr, lat;
      bit ok;
      do_reset();
      ptr   = 0;
      req_v = '0;
      while (req_v == '0) req_v = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, DW'($urandom), DW'($urandom));
      bus.req = req_v;
      for (int j = 0; j < 20; j++) begin
         lat = $urandom_range(1, 6);
         model_lat = lat;
         wait_grant(g, ok);
         w = rr_pick(ptr, req_v);
         n_chk++; if (!ok || g !== onehot(w)) begin n_err++; $display("FAIL rand_grant[%0d]: got %b want %b req=%b", j, g, onehot(w), req_v); end
         n_chk++; if (bus.mult_a !== op_a[w] || bus.mult_b !== op_b[w]) begin
            n_err++; $display("FAIL rand_operands[%0d]: got %h/%h want %h/%h", j, bus.mult_a, bus.mult_b, op_a[w], op_b[w]); end
         if ($urandom_range(0, 3) == 0) begin
            req_v[w] = 1'b0;
            bus.req  = req_v;
         end
         wait_end(d, e, cyc, ok);
         n_chk++; if (!ok || d !== onehot(w) || e !== '0) begin n_err++; $display("FAIL rand_done[%0d]: done=%b err=%b want %b", j, d, e, onehot(w)); end
         n_chk++; if (bus.result !== exp_prod(op_a[w], op_b[w])) begin
            n_err++; $display("FAIL rand_result[%0d]: got %h want %h", j, bus.result, exp_prod(op_a[w], op_b[w])); end
         n_chk++; if (cyc != lat + 1) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", j, cyc, lat + 1); end
         ptr = (w + 1) % N;
         req_v[w] = 1'b0;
         nw = N'($urandom);
         for (int i = 0; i < N; i++) begin
            if (nw[i] && !req_v[i]) set_op(i, DW'($urandom), DW'($urandom));
         end
         req_v = req_v | nw;
         if (req_v == '0) begin
            w = $urandom_range(0, N - 1);
            set_op(w, DW'($urandom), DW'($urandom));
            req_v = onehot(w);
         end
         if (j == 19) req_v = '0;
         bus.req = req_v;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [N-1:0] g, d, e;
      logic [RW-1:0] res0;
      int cyc;
      bit ok;
      res0 = bus.result;
      model_mode = 1;
      set_op(1, 8'd11, 8'd13);
      bus.req = 4'b0010;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== 4'b0010) begin n_err++; $display("FAIL to_grant: got %b want 0010", g); end
      wait_end(d, e, cyc, ok);
      n_chk++; if (!ok || e !== 4'b0010 || d !== '0) begin n_err++; $display("FAIL to_err: err=%b done=%b want 0010/0000", e, d); end
      n_chk++; if (cyc != TIMEOUT + 1) begin n_err++; $display("FAIL to_cycles: got %0d want %0d", cyc, TIMEOUT + 1); end
      n_chk++; if (bus.result !== res0) begin n_err++; $display("FAIL to_result: got %h want %h", bus.result, res0); end
      n_chk++; if (bus.grant !== '0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL to_release: grant=%b busy=%b want 0", bus.grant, bus.busy); end
      model_mode = 0;
      model_lat  = 2;
      set_op(0, 8'h81, 8'h02);
      set_op(2, 8'h7F, 8'h7F);
      bus.req = 4'b0111;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== onehot(rr_pick(2, 4'b0111))) begin n_err++; $display("FAIL to_next_grant: got %b want 0100", g); end
      wait_end(d, e, cyc, ok);
      n_chk++; if (!ok || d !== 4'b0100 || bus.result !== exp_prod(8'h7F, 8'h7F)) begin
         n_err++; $display("FAIL to_next_done: done=%b result=%h want 0100/%h", d, bus.result, exp_prod(8'h7F, 8'h7F)); end
      bus.req = 4'b0011;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== onehot(rr_pick(3, 4'b0011))) begin n_err++; $display("FAIL to_wrap_grant: got %b want 0001", g); end
      wait_end(d, e, cyc, ok);
      bus.req = '0;
      n_chk++; if (!ok || d !== 4'b0001 || bus.result !== exp_prod(8'h81, 8'h02)) begin
         n_err++; $display("FAIL to_wrap_done: done=%b result=%h want 0001/%h", d, bus.result, exp_prod(8'h81, 8'h02)); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_stale();
      logic [N-1:0] g, d, e;
      int cyc;
      bit ok;
      time t_done;
      model_mode = 2;
      model_lat  = 3;
      set_op(0, 8'd9, 8'hFD);
      bus.req = 4'b0001;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== 4'b0001) begin n_err++; $display("FAIL stale_grant: got %b want 0001", g); end
      wait_end(d, e, cyc, ok);
      t_done = $time;
      bus.req = '0;
      n_chk++; if (!ok || d !== 4'b0001 || e !== '0) begin n_err++; $display("FAIL stale_done: done=%b err=%b want 0001/0000", d, e); end
      n_chk++; if (t_done - t_fall != 20) begin n_err++; $display("FAIL stale_timing: done %0t after ready fall, want 20", t_done - t_fall); end
      n_chk++; if (bus.result !== 16'hFFE5) begin n_err++; $display("FAIL stale_result: got %h want ffe5", bus.result); end
      model_mode = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] g, d, e;
      int cyc;
      bit ok, saw;
      model_mode = 1;
      set_op(3, 8'd6, 8'd7);
      bus.req = 4'b1000;
      wait_grant(g, ok);
      n_chk++; if (!ok || g !== 4'b1000) begin n_err++; $display("FAIL rm_grant: got %b want 1000", g); end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if ({bus.grant, bus.done, bus.err} !== '0 || bus.busy !== 1'b0 || bus.mult_start !== 1'b0) begin
         n_err++; $display("FAIL rm_async_ctrl: grant=%b done=%b err=%b busy=%b start=%b want 0", bus.grant, bus.done, bus.err, bus.busy, bus.mult_start); end
      n_chk++; if (bus.result !== '0 || bus.mult_a !== '0 || bus.mult_b !== '0) begin
         n_err++; $display("FAIL rm_async_data: result=%h a=%h b=%h want 0", bus.result, bus.mult_a, bus.mult_b); end
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if ((bus.done | bus.err) !== '0) saw = 1'b1;
      end
      model_mode = 0;
      model_lat  = 2;
      rst_n = 1'b1;
      wait_grant(g, ok);
      n_chk++; if (saw) begin n_err++; $display("FAIL rm_no_pulse: done/err pulse seen across reset, want none"); end
      n_chk++; if (!ok || g !== 4'b1000) begin n_err++; $display("FAIL rm_regrant: got %b want 1000", g); end
      wait_end(d, e, cyc, ok);
      bus.req = '0;
      n_chk++; if (!ok || d !== 4'b1000 || bus.result !== 16'd42) begin n_err++; $display("FAIL rm_done: done=%b result=%h want 1000/002a", d, bus.result); end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_round_robin();
      test_random();
      test_timeout();
      test_stale();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
